// File: rtl/ir_pkg.sv
// Shared types and constants for the IR transmit scheduler.
package ir_pkg;

    localparam int FRAME35_W = 35;
    localparam int FRAME32_W = 32;
    localparam int CLK_HZ    = 125000000;

    // Canned frame: AC power off.
    localparam logic [FRAME35_W-1:0] POWER_OFF_35 = 35'h4_0201_0052;
    localparam logic [FRAME32_W-1:0] POWER_OFF_32 = 32'h0804_0006;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_LAUNCH,
        ST_WAIT_DONE,
        ST_GAP
    } ir_state_t;

    typedef struct packed {
        logic [FRAME35_W-1:0] p35;
        logic [FRAME32_W-1:0] p32;
    } ir_frame_t;

    // Index width that stays legal for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ir_tx_scheduler_if.sv
// Request/launch bus between command sources, the scheduler and the IR transmitter.
// slave = scheduler side, master = sources + transmitter side.
interface ir_tx_scheduler_if
    import ir_pkg::*;
#(
    parameter int NUM_REQ = 3
);
    localparam int IDX_W = idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*FRAME35_W-1:0] req_data35;
    logic [NUM_REQ*FRAME32_W-1:0] req_data32;
    logic [NUM_REQ-1:0]           gnt;
    logic                         tx_start;
    logic [FRAME35_W-1:0]         tx_data35;
    logic [FRAME32_W-1:0]         tx_data32;
    logic                         tx_done;
    logic                         busy;
    logic [IDX_W-1:0]             last_src;
    logic                         tx_err;

    modport master (
        output req, req_data35, req_data32, tx_done,
        input  gnt, tx_start, tx_data35, tx_data32, busy, last_src, tx_err
    );

    modport slave (
        input  req, req_data35, req_data32, tx_done,
        output gnt, tx_start, tx_data35, tx_data32, busy, last_src, tx_err
    );

endinterface

// File: rtl/ir_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr wins.
module rr_arbiter
    import ir_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [IDX_W-1:0]   win_idx,
    output logic               any
);

    logic [IDX_W-1:0] kk;

    // Walk the requests in rotated order and keep the first hit.
    always_comb begin
        gnt_oh  = '0;
        win_idx = '0;
        any     = 1'b0;
        kk      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            kk = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!any && req[kk]) begin
                any        = 1'b1;
                win_idx    = kk;
                gnt_oh[kk] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ir_tx_scheduler.sv
// IR transmit scheduler: round-robin arbitration among command sources,
// frame latch, start/done handshake with the transmitter, inter-frame gap
// and transmit timeout.
// Optional: IR_REPEAT_EN sends each granted frame twice (one gnt, two launches).
module ir_tx_scheduler
    import ir_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int GAP_CYCLES     = 12500000,
    parameter int TIMEOUT_CYCLES = 25000000
) (
    input  logic               clk,
    input  logic               rst,
    ir_tx_scheduler_if.slave   bus
);

    localparam int IDX_W   = idx_w(NUM_REQ);
    localparam int CNT_MAX = max2(GAP_CYCLES, TIMEOUT_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(CNT_MAX);

    ir_state_t state_q, state_d;
    ir_frame_t frame_q, frame_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               start_q, start_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    // One counter serves both the timeout and the gap; they never overlap.
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
`ifdef IR_REPEAT_EN
    logic               copy_q, copy_d;
`endif

    logic [NUM_REQ-1:0]                d_gnt;
    logic [IDX_W-1:0]                  win_idx, ptr_nxt;
    logic                              win_any;
    logic [NUM_REQ-1:0][FRAME35_W-1:0] d35;
    logic [NUM_REQ-1:0][FRAME32_W-1:0] d32;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign d35[k] = bus.req_data35[k*FRAME35_W +: FRAME35_W];
        assign d32[k] = bus.req_data32[k*FRAME32_W +: FRAME32_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req     (bus.req),
        .ptr     (ptr_q),
        .gnt_oh  (d_gnt),
        .win_idx (win_idx),
        .any     (win_any)
    );

    assign ptr_nxt = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + IDX_W'(1);
    assign cnt_inc = (cnt_q == CNT_TOP) ? cnt_q : cnt_q + CNT_W'(1);

    assign bus.gnt       = gnt_q;
    assign bus.tx_start  = start_q;
    assign bus.tx_err    = err_q;
    assign bus.tx_data35 = frame_q.p35;
    assign bus.tx_data32 = frame_q.p32;
    assign bus.last_src  = last_q;
    assign bus.busy      = (state_q != ST_IDLE);

    // Next state and next registered outputs; pulses default low each cycle.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        gnt_d   = '0;
        start_d = 1'b0;
        err_d   = 1'b0;
        last_d  = last_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
`ifdef IR_REPEAT_EN
        copy_d  = copy_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|bus.req) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                if (win_any) begin
                    gnt_d   = d_gnt;
                    frame_d = '{p35: d35[win_idx], p32: d32[win_idx]};
                    last_d  = win_idx;
                    ptr_d   = ptr_nxt;
                    state_d = ST_LAUNCH;
`ifdef IR_REPEAT_EN
                    copy_d  = 1'b1;
`endif
                end else begin
                    // Request withdrawn before the grant cycle.
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (bus.tx_done) begin
                    // Done beats a timeout landing on the same cycle.
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else if (cnt_q >= TO_LAST) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_GAP;
`ifdef IR_REPEAT_EN
                    copy_d  = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_GAP: begin
                if (cnt_q >= GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
`ifdef IR_REPEAT_EN
                    if (copy_q) begin
                        copy_d  = 1'b0;
                        state_d = ST_LAUNCH;
                    end
`endif
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            gnt_q   <= '0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
`ifdef IR_REPEAT_EN
            copy_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            gnt_q   <= gnt_d;
            start_q <= start_d;
            err_q   <= err_d;
            last_q  <= last_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
`ifdef IR_REPEAT_EN
            copy_q  <= copy_d;
`endif
        end
    end

endmodule

// File: tb/tb_ir_tx_scheduler.sv
// Directed bench for ir_tx_scheduler with a grant scoreboard.
module tb_ir_tx_scheduler;
    import ir_pkg::*;

    localparam int NR  = 3;
    localparam int GAP = 20;
    localparam int TO  = 50;

    typedef struct {
        int          src;
        logic [34:0] d35;
        logic [31:0] d32;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    logic [34:0] f35 [NR];
    logic [31:0] f32 [NR];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ir_tx_scheduler_if #(.NUM_REQ(NR)) bus ();

    ir_tx_scheduler #(
        .NUM_REQ        (NR),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(negedge clk);
    endtask

    task automatic push_exp(input int src);
        exp_t e;
        e.src = src;
        e.d35 = f35[src];
        e.d32 = f32[src];
        exp_q.push_back(e);
    endtask

    // Wait for gnt, compare with scoreboard head, then check the launch cycle.
    task automatic expect_grant(output int g, output int s);
        int   n;
        exp_t e;
        n = 0;
        while (bus.gnt == '0 && n < 200) begin nx(); n++; end
        chk("gnt_seen", 64'(bus.gnt != '0), 64'(1));
        g = cyc;
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 64'(exp_q.size()), 64'(1));
            e.src = 0; e.d35 = '0; e.d32 = '0;
        end else begin
            e = exp_q.pop_front();
        end
        chk("gnt_onehot", 64'(bus.gnt), 64'(1 << e.src));
        chk("last_src", 64'(bus.last_src), 64'(e.src));
        chk("tx_data35", 64'(bus.tx_data35), 64'(e.d35));
        chk("tx_data32", 64'(bus.tx_data32), 64'(e.d32));
        nx();
        chk("tx_start", 64'(bus.tx_start), 64'(1));
        chk("gnt_pulse", 64'(bus.gnt), 64'(0));
        chk("tx_data35_hold", 64'(bus.tx_data35), 64'(e.d35));
        s = cyc;
    endtask

    // Drive tx_done during cycle s+d.
    task automatic done_at(input int s, input int d);
        int n;
        n = 0;
        while (cyc < s + d && n < 500) begin nx(); n++; end
        bus.tx_done = 1'b1;
        nx();
        bus.tx_done = 1'b0;
    endtask

    task automatic wait_idle(output int c);
        int n;
        n = 0;
        while (bus.busy && n < 300) begin nx(); n++; end
        chk("idle_reached", 64'(bus.busy), 64'(0));
        c = cyc;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"}, 64'(bus.gnt), 64'(0));
        chk({tag, "_start"}, 64'(bus.tx_start), 64'(0));
        chk({tag, "_d35"}, 64'(bus.tx_data35), 64'(0));
        chk({tag, "_d32"}, 64'(bus.tx_data32), 64'(0));
        chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
        chk({tag, "_last"}, 64'(bus.last_src), 64'(0));
        chk({tag, "_err"}, 64'(bus.tx_err), 64'(0));
    endtask

    initial begin
        int t0, g, s, c, n, prev, errs;
        logic seen;
        f35[0] = 35'h1_1111_0001; f32[0] = 32'hA5A5_0001;
        f35[1] = 35'h4_0201_0052; f32[1] = 32'h0804_0006;
        f35[2] = 35'h7_ABCD_1234; f32[2] = 32'h1234_5678;
        bus.req = '0;
        bus.tx_done = 1'b0;
        for (int k = 0; k < NR; k++) begin
            bus.req_data35[k*35 +: 35] = f35[k];
            bus.req_data32[k*32 +: 32] = f32[k];
        end
        rst = 1'b0;
        repeat (3) nx();
        chk_reset_outputs("reset");
        rst = 1'b1;
        nx();

`ifdef IR_REPEAT_EN
        // Each frame goes out twice with a single grant.
        bus.req = 3'b001;
        push_exp(0);
        expect_grant(g, s);
        bus.req = '0;
        done_at(s, 10);
        n = 0; seen = 1'b0;
        while (!bus.tx_start && n < 200) begin
            if (bus.gnt != '0) seen = 1'b1;
            nx(); n++;
        end
        chk("rep_second_start", 64'(bus.tx_start), 64'(1));
        chk("rep_no_second_gnt", 64'(seen), 64'(0));
        chk("rep_spacing_ok", 64'((cyc - s) >= GAP + 10), 64'(1));
        chk("rep_d35", 64'(bus.tx_data35), 64'(f35[0]));
        chk("rep_d32", 64'(bus.tx_data32), 64'(f32[0]));
        done_at(cyc, 10);
        wait_idle(c);
        chk("rep_idle_gap", 64'(c - (cyc - 0)), 64'(0));
`else
        // Single request: gnt two cycles after req, tx_start one after gnt.
        t0 = cyc;
        bus.req = 3'b010;
        push_exp(1);
        nx();
        chk("single_busy_grant", 64'(bus.busy), 64'(1));
        chk("single_no_early_gnt", 64'(bus.gnt), 64'(0));
        expect_grant(g, s);
        bus.req = '0;
        chk("single_gnt_lat", 64'(g - t0), 64'(2));
        chk("single_start_lat", 64'(s - t0), 64'(3));
        done_at(s, 10);
        wait_idle(c);
        chk("single_idle_cycle", 64'(c - s), 64'(10 + 1 + GAP));

        // tx_done while idle does nothing.
        bus.tx_done = 1'b1;
        nx();
        bus.tx_done = 1'b0;
        nx();
        chk("idle_done_busy", 64'(bus.busy), 64'(0));
        chk("idle_done_start", 64'(bus.tx_start), 64'(0));

        // Request withdrawn before the grant cycle: no gnt.
        bus.req = 3'b001;
        nx();
        bus.req = '0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            nx();
            if (bus.gnt != '0 || bus.tx_start) seen = 1'b1;
        end
        chk("withdraw_no_gnt", 64'(seen), 64'(0));
        chk("withdraw_idle", 64'(bus.busy), 64'(0));

        // Timeout: pointer is 2, so req 001 goes to source 0.
        bus.req = 3'b001;
        push_exp(0);
        expect_grant(g, s);
        bus.req = '0;
        n = 0;
        while (!bus.tx_err && n < TO + 10) begin nx(); n++; end
        chk("timeout_latency", 64'(n), 64'(TO));
        c = cyc;
        nx();
        chk("timeout_pulse", 64'(bus.tx_err), 64'(0));
        chk("timeout_in_gap", 64'(bus.busy), 64'(1));
        wait_idle(n);
        chk("timeout_gap_len", 64'(n - c), 64'(GAP));

        // tx_done on the last timeout cycle wins; no tx_err.
        bus.req = 3'b100;
        push_exp(2);
        expect_grant(g, s);
        bus.req = '0;
        done_at(s, TO - 1);
        errs = 0;
        n = 0;
        while (bus.busy && n < 100) begin
            if (bus.tx_err) errs++;
            nx(); n++;
        end
        chk("simul_no_err", 64'(errs), 64'(0));
        chk("simul_idle_cycle", 64'(cyc - s), 64'(TO + GAP));

        // Contention: pointer back at 0, order 0,1,2,0.
        bus.req = 3'b111;
        push_exp(0); push_exp(1); push_exp(2); push_exp(0);
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            expect_grant(g, s);
            if (i == 3) bus.req = '0;
            if (prev >= 0) begin
                total++;
                assert ((s - prev) >= 10 + GAP + 3) else begin
                    bad++;
                    $error("FAIL contention_spacing observed=%0d expected>=%0d", s - prev, 10 + GAP + 3);
                end
            end
            prev = s;
            done_at(s, 10);
        end
        wait_idle(c);

        // Reset mid-frame clears everything including the pointer.
        bus.req = 3'b010;
        push_exp(1);
        expect_grant(g, s);
        bus.req = '0;
        repeat (5) nx();
        chk("midrst_busy_before", 64'(bus.busy), 64'(1));
        rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        nx();
        rst = 1'b1;
        bus.req = 3'b110;
        push_exp(1);
        expect_grant(g, s);
        bus.req = '0;
        done_at(s, 10);
        wait_idle(c);
`endif

        chk("sb_empty", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ir_tx_scheduler.md
Name: ir_tx_scheduler

Overview:
- Sequences the AC infrared transmitter: arbitrates between NUM_REQ command sources (key panel, host UART, auto-timer), latches the winner's 35-bit + 32-bit frame, and launches the transmitter with a start/done handshake.
- Enforces a minimum inter-frame gap and a transmit timeout.
- Sits between command generators and the IR frame transmitter; the transmitter no longer compares frames itself to detect new commands.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 has priority after reset.
- GAP_CYCLES, 12500000, idle cycles after each frame (100 ms at 125 MHz).
- TIMEOUT_CYCLES, 25000000, maximum cycles from tx_start to tx_done (200 ms).

Ports:
- clk  in  1  system clock, 125 MHz.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  level request per source; held until the matching gnt.
- req_data35  in  NUM_REQ*35  flattened first-part frames; source k at bits [k*35+34:k*35].
- req_data32  in  NUM_REQ*32  flattened second-part frames; source k at bits [k*32+31:k*32].
- gnt  out  NUM_REQ  one-hot, one-cycle pulse; frame latched that cycle.
- tx_start  out  1  one-cycle launch pulse to the transmitter.
- tx_data35  out  35  latched frame part 1; stable from tx_start until the return to IDLE.
- tx_data32  out  32  latched frame part 2; same stability rule.
- tx_done  in  1  one-cycle pulse from the transmitter at the end of the frame.
- busy  out  1  high in every state except IDLE.
- last_src  out  clog2(NUM_REQ)  index of the most recently granted source.
- tx_err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; gnt=0; tx_start=0; tx_data35=0; tx_data32=0; busy=0; last_src=0; tx_err=0; round-robin pointer=0; all counters=0.
- States: IDLE, GRANT, LAUNCH, WAIT_DONE, GAP.
- IDLE: if any req bit is set, go to GRANT next cycle. Otherwise stay. A tx_done seen in IDLE is ignored.
- GRANT (1 cycle):
  - Round-robin search starts at the pointer; the first set req bit wins.
  - gnt[win]=1; latch that source's data into tx_data35/tx_data32.
  - last_src=win; pointer=(win+1) mod NUM_REQ.
  - Go to LAUNCH.
  - If req has dropped by this cycle (withdrawn), emit no grant and return to IDLE.
- LAUNCH (1 cycle): tx_start=1; clear the timeout counter; go to WAIT_DONE.
- WAIT_DONE:
  - Count cycles.
  - tx_done=1 -> GAP; clear the gap counter.
  - Counter reaches TIMEOUT_CYCLES-1 without tx_done -> tx_err pulse, then GAP.
  - If tx_done and timeout occur in the same cycle, tx_done wins and there is no tx_err.
- GAP: count GAP_CYCLES cycles, then go to IDLE. Requests arriving during GAP wait; none are lost, because req is a level.
- Latency: req rising in IDLE -> gnt 2 cycles later -> tx_start 1 cycle after gnt.
- Back-to-back: minimum tx_start spacing is transmit time + GAP_CYCLES + 3 cycles.
- Counter widths: clog2(max(GAP_CYCLES, TIMEOUT_CYCLES)+1). Counters saturate and never wrap.
- A requester re-asserting req immediately after its gnt is served only after all other pending sources (fairness).
- Reset mid-frame: tx_start is already low; the transmitter is reset by the same rst.

Optional Feature:
- Macro: IR_REPEAT_EN.
- Defined: every frame is transmitted twice. After the first GAP, the block returns to LAUNCH with the same latched data, with no re-arbitration and no second gnt. A timeout on either copy pulses tx_err and skips any remaining copy.
- Undefined: single transmission, as above.

Decomposition:
- Package ir_pkg:
  - FRAME35_W=35, FRAME32_W=32, CLK_HZ=125000000.
  - State enum for this block.
  - Canned frames, e.g. POWER_OFF_35 / POWER_OFF_32.
- Sub-module rr_arbiter: combinational round-robin pick (req, pointer -> one-hot winner plus index), parameterised by NUM_REQ, so it can be reused.

Test Plan:
- Single request: req=3'b010, data35=35'h4_0201_0052, data32=32'h0804_0006 -> gnt=010 at cycle 2, tx_start at cycle 3, tx_data matches, last_src=1.
- Contention: req=3'b111 held, tx_done returned 10 cycles after each tx_start, GAP_CYCLES=20 -> grant order 0,1,2,0; tx_start spacing ≥ 33 cycles.
- Timeout: no tx_done, TIMEOUT_CYCLES=50 -> tx_err pulses exactly 50 cycles after tx_start; the block then passes through GAP to IDLE.
- Simultaneous: tx_done on the final timeout cycle -> no tx_err, normal GAP.
- Reset mid-WAIT_DONE: rst low for 1 cycle -> all outputs 0 immediately, pointer=0; after release, req=3'b110 is granted to source 1.
- IR_REPEAT_EN defined: req=3'b001 -> one gnt, two tx_start pulses separated by GAP_CYCLES + the tx_done latency, identical tx_data.
